// File: rtl/crc_frame_checker.sv
// ============================================================================
// crc_frame_checker: serial CRC-16 frame checker, MSB-first payload + CRC.
// Optional idle-gap timeout abort enabled by macro CRC_FRAME_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_frame_checker #(
    parameter int          PAYLOAD_LEN = 128,
    parameter logic [15:0] POLY        = 16'h1021,
    parameter logic [15:0] INIT        = 16'hFFFF,
    parameter int          TIMEOUT     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial,
    input  logic        enable,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic [15:0] crc_calc,
    output logic [15:0] crc_rx,
    output logic        err
);

    localparam int               CNT_W      = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0] C_LAST_PAY = CNT_W'(PAYLOAD_LEN - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [3:0]       r_chk_cnt;
    logic [15:0]      r_crc;
    logic [15:0]      r_rx;
    logic             r_ok;

    logic        w_start;
    logic [15:0] w_crc_base;
    logic [15:0] w_crc_next;
    logic [15:0] w_rx_next;

    // A new frame may begin from IDLE or directly out of the DONE cycle.
    assign w_start    = enable && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_crc_base = w_start ? INIT : r_crc;
    assign w_crc_next = {w_crc_base[14:0], 1'b0} ^ ((w_crc_base[15] ^ serial) ? POLY : 16'h0000);
    assign w_rx_next  = {r_rx[14:0], serial};

`ifdef CRC_FRAME_TIMEOUT_EN
    localparam int              GAP_W      = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(TIMEOUT - 1);

    logic [GAP_W-1:0] r_gap;
    logic             r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_chk_cnt <= '0;
            r_crc     <= INIT;
            r_rx      <= 16'h0000;
            r_ok      <= 1'b0;
`ifdef CRC_FRAME_TIMEOUT_EN
            r_gap     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
`ifdef CRC_FRAME_TIMEOUT_EN
            r_err <= 1'b0;
            if (enable || (r_state == S_IDLE) || (r_state == S_DONE)) begin
                r_gap <= '0;
            end
`endif
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (enable) begin
                        r_crc     <= w_crc_next;
                        r_rx      <= 16'h0000;
                        r_ok      <= 1'b0;
                        r_bit_cnt <= CNT_W'(1);
                        r_chk_cnt <= '0;
                        r_state   <= (PAYLOAD_LEN == 1) ? S_CHECK : S_PAYLOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (enable) begin
                        r_crc     <= w_crc_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == C_LAST_PAY) begin
                            r_state <= S_CHECK;
                        end
                    end
`ifdef CRC_FRAME_TIMEOUT_EN
                    else if (r_gap == C_GAP_LAST) begin
                        r_err   <= 1'b1;
                        r_ok    <= 1'b0;
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
`endif
                end
                S_CHECK: begin
                    if (enable) begin
                        r_rx      <= w_rx_next;
                        r_chk_cnt <= r_chk_cnt + 1'b1;
                        // Compare against the shifted value so crc_ok lands with done.
                        if (r_chk_cnt == 4'd15) begin
                            r_ok    <= (w_rx_next == r_crc);
                            r_state <= S_DONE;
                        end
                    end
`ifdef CRC_FRAME_TIMEOUT_EN
                    else if (r_gap == C_GAP_LAST) begin
                        r_err   <= 1'b1;
                        r_ok    <= 1'b0;
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign done     = (r_state == S_DONE);
    assign crc_ok   = r_ok;
    assign crc_calc = r_crc;
    assign crc_rx   = r_rx;

`ifdef CRC_FRAME_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc_frame_checker.sv
// ============================================================================
// tb_crc_frame_checker: directed vector bench for crc_frame_checker, 72-bit payload.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crc_frame_checker;

    localparam int           PAYLOAD_LEN = 72;
    localparam logic [71:0]  C_PAYLOAD   = 72'h313233343536373839;

    logic        clk;
    logic        rst;
    logic        serial;
    logic        enable;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic        err;

    int n_vec;
    int n_bad;

    crc_frame_checker #(
        .PAYLOAD_LEN (PAYLOAD_LEN),
        .POLY        (16'h1021),
        .INIT        (16'hFFFF),
        .TIMEOUT     (32)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .serial   (serial),
        .enable   (enable),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_calc (crc_calc),
        .crc_rx   (crc_rx),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] crc_field;
        int          gap1_at;
        int          gap1_len;
        int          gap2_at;
        int          gap2_len;
        logic [15:0] exp_calc;
        logic [15:0] exp_rx;
        logic        exp_ok;
        int          exp_span;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic gap(input int len, inout int span, inout int busy_cnt,
                       inout int done_cnt, inout int err_cnt);
        for (int k = 0; k < len; k++) begin
            enable = 1'b0;
            @(posedge clk);
            #1;
            span++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    endtask

    // span counts edges from the first-bit edge to the edge that exposes done.
    task automatic send_frame(input logic [15:0] crcf, input int g1a, input int g1l,
                              input int g2a, input int g2l, output int span,
                              output int busy_cnt, output int early_done,
                              output int err_cnt, output logic [15:0] calc72);
        logic [87:0] f;
        f          = {C_PAYLOAD, crcf};
        span       = 0;
        busy_cnt   = 0;
        early_done = 0;
        err_cnt    = 0;
        calc72     = 16'h0000;
        for (int i = 0; i < 88; i++) begin
            serial = f[87-i];
            enable = 1'b1;
            @(posedge clk);
            #1;
            span++;
            if (i == 71) calc72 = crc_calc;
            if (err) err_cnt++;
            if (i < 87) begin
                if (busy) busy_cnt++;
                if (done) early_done++;
                if (i + 1 == g1a) gap(g1l, span, busy_cnt, early_done, err_cnt);
                if (i + 1 == g2a) gap(g2l, span, busy_cnt, early_done, err_cnt);
            end
        end
        enable = 1'b0;
        serial = 1'b0;
    endtask

    task automatic frame_checks(input string tag, input vec_t v, input int span,
                                input int busy_cnt, input int early_done,
                                input int err_cnt, input logic [15:0] calc72);
        chk({tag, " span"},        32'(span),         32'(v.exp_span));
        chk({tag, " busy_cycles"}, 32'(busy_cnt + 1), 32'(v.exp_span));
        chk({tag, " early_done"},  32'(early_done),   32'd0);
        chk({tag, " err"},         32'(err_cnt),      32'd0);
        chk({tag, " calc_at_72"},  32'(calc72),       32'(v.exp_calc));
        chk({tag, " done"},        32'(done),         32'd1);
        chk({tag, " busy_in_done"},32'(busy),         32'd0);
        chk({tag, " crc_ok"},      32'(crc_ok),       32'(v.exp_ok));
        chk({tag, " crc_calc"},    32'(crc_calc),     32'(v.exp_calc));
        chk({tag, " crc_rx"},      32'(crc_rx),       32'(v.exp_rx));
    endtask

    initial begin
        int          span;
        int          busy_cnt;
        int          early_done;
        int          err_cnt;
        int          stray;
        logic [15:0] calc72;
        vec_t        v;

        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        serial = 1'b0;
        enable = 1'b0;

        vecs[0] = '{16'h29B1,  0, 0,  0, 0, 16'h29B1, 16'h29B1, 1'b1,  88};
        vecs[1] = '{16'h29B0,  0, 0,  0, 0, 16'h29B1, 16'h29B0, 1'b0,  88};
        vecs[2] = '{16'h29B1, 40, 5, 80, 5, 16'h29B1, 16'h29B1, 1'b1,  98};
        vecs[3] = '{16'h0000, 72, 3,  0, 0, 16'h29B1, 16'h0000, 1'b0,  91};
        vecs[4] = '{16'h29B1,  1, 7, 87, 2, 16'h29B1, 16'h29B1, 1'b1,  97};

        #2;
        chk("reset busy",     32'(busy),     32'd0);
        chk("reset done",     32'(done),     32'd0);
        chk("reset crc_ok",   32'(crc_ok),   32'd0);
        chk("reset err",      32'(err),      32'd0);
        chk("reset crc_calc", 32'(crc_calc), 32'hFFFF);
        chk("reset crc_rx",   32'(crc_rx),   32'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 5; n++) begin
            v = vecs[n];
            send_frame(v.crc_field, v.gap1_at, v.gap1_len, v.gap2_at, v.gap2_len,
                       span, busy_cnt, early_done, err_cnt, calc72);
            frame_checks($sformatf("vec%0d", n), v, span, busy_cnt, early_done, err_cnt, calc72);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done_pulse_end", n), 32'(done),   32'd0);
            chk($sformatf("vec%0d crc_ok_held", n),    32'(crc_ok), 32'(v.exp_ok));
            repeat (2) @(posedge clk);
            #1;
        end

        // Back-to-back: second frame's first bit is taken in the DONE cycle.
        send_frame(16'h29B1, 0, 0, 0, 0, span, busy_cnt, early_done, err_cnt, calc72);
        frame_checks("b2b first", vecs[0], span, busy_cnt, early_done, err_cnt, calc72);
        send_frame(16'h29B0, 0, 0, 0, 0, span, busy_cnt, early_done, err_cnt, calc72);
        frame_checks("b2b second", vecs[1], span, busy_cnt, early_done, err_cnt, calc72);
        @(posedge clk);
        #1;
        chk("b2b idle after", 32'(busy | done), 32'd0);

        // Asynchronous reset after bit 30, then a clean frame.
        for (int i = 0; i < 30; i++) begin
            serial = C_PAYLOAD[71-i];
            enable = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset busy",     32'(busy),     32'd0);
        chk("async reset crc_calc", 32'(crc_calc), 32'hFFFF);
        chk("async reset crc_rx",   32'(crc_rx),   32'h0000);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stray = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        chk("aborted frame stray done/busy", 32'(stray), 32'd0);
        send_frame(16'h29B1, 0, 0, 0, 0, span, busy_cnt, early_done, err_cnt, calc72);
        frame_checks("post-reset", vecs[0], span, busy_cnt, early_done, err_cnt, calc72);
        repeat (2) @(posedge clk);
        #1;

`ifdef CRC_FRAME_TIMEOUT_EN
        // 32 idle cycles after bit 10 abort the frame.
        for (int i = 0; i < 10; i++) begin
            serial = C_PAYLOAD[71-i];
            enable = 1'b1;
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        stray  = 0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            if (err || !busy || done) stray++;
        end
        chk("timeout early err/busy", 32'(stray), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout err",    32'(err),    32'd1);
        chk("timeout busy",   32'(busy),   32'd0);
        chk("timeout done",   32'(done),   32'd0);
        chk("timeout crc_ok", 32'(crc_ok), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout err pulse end", 32'(err), 32'd0);
        send_frame(16'h29B1, 0, 0, 0, 0, span, busy_cnt, early_done, err_cnt, calc72);
        frame_checks("post-timeout", vecs[0], span, busy_cnt, early_done, err_cnt, calc72);
`else
        // Without the timeout option a long gap is legal.
        v = '{16'h29B1, 10, 40, 0, 0, 16'h29B1, 16'h29B1, 1'b1, 128};
        send_frame(v.crc_field, v.gap1_at, v.gap1_len, v.gap2_at, v.gap2_len,
                   span, busy_cnt, early_done, err_cnt, calc72);
        frame_checks("long gap", v, span, busy_cnt, early_done, err_cnt, calc72);
`endif
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
